layer_pipeline_sched: RTL and testbench
=======================================

// Module: layer_pipeline_sched
// PURPOSE
//  Sequences start and func-start pulses for the layer chain of the LeNet-5 CIM accelerator
//  (conv, pool, conv, pool, fc, fc, fc). It tracks one frame token per layer. Layers overlap
//  in a pipeline, and back-pressure holds a layer until its successor's input buffer is free.
//  Sits between the host frame interface and the start, busy and next-busy pins of the layer top.
// PARAMETERS
//  NUM_LAYERS   7           layers in the chain; bit k of every vector port = layer k+1
//  CIM_MASK     7'b1110101  1 = layer has a CIM phase (drives o_busy); 0 = pool layer
//  BUSY_TMO     16          cycles allowed for a CIM layer's busy to rise after its start pulse
//  CNT_W        16          width of the completed-frame counter
// PORTS
//  clk            in   1           single clock, rising edge
//  rst            in   1           asynchronous, active-low reset
//  i_frame_valid  in   1           host offers a new frame (input buffer of layer 1 filled)
//  o_frame_ready  out  1           scheduler accepts the frame this cycle (valid&ready)
//  i_busy         in   NUM_LAYERS  per-layer CIM busy (ignored where CIM_MASK=0)
//  i_next_busy    in   NUM_LAYERS  per-layer downstream busy, as seen by that layer's func stage
//  o_start        out  NUM_LAYERS  one-cycle start pulse per layer
//  o_func_start   out  NUM_LAYERS  one-cycle func-start pulse per layer
//  o_frame_done   out  1           one-cycle pulse when the last layer completes a frame
//  o_frame_cnt    out  CNT_W       completed frames, wraps at 2^CNT_W
//  o_err          out  NUM_LAYERS  sticky busy-timeout flag per layer
//  i_clr_err      in   1           synchronous clear of o_err and restart of errored layers
// BEHAVIOUR
//  - Reset (rst=0, async): all outputs 0, every layer FSM in IDLE, pending flags 0, counters 0.
//  - pend[k]: "input buffer of layer k holds a frame".
//    - pend[0] is set on frame accept; o_frame_ready = !pend[0].
//    - pend[k+1] is set when layer k leaves FUNC; pend[k] is cleared in the cycle o_start[k] fires.
//  - Per-layer FSM states: IDLE, START, WBUSY, WDONE, WFUNC, FUNC, ERR.
//    - IDLE  -> START when pend[k].
//    - START: o_start[k]=1 for 1 cycle. Next state is WBUSY if CIM_MASK[k], else WFUNC.
//    - WBUSY: wait for i_busy[k]=1, then WDONE. Timeout counter runs from 0. Reaching
//      BUSY_TMO-1 without busy sets o_err[k] and moves to ERR.
//    - WDONE: wait for i_busy[k]=0, then WFUNC.
//    - WFUNC: wait until i_next_busy[k]=0 and, for k<NUM_LAYERS-1, pend[k+1]=0 (back-pressure).
//      Then FUNC.
//    - FUNC:  o_func_start[k]=1 for 1 cycle. Set pend[k+1], or for the last layer pulse
//      o_frame_done and increment o_frame_cnt. Next state IDLE.
//    - ERR:   hold, with no pulses. i_clr_err clears o_err[k] and returns the FSM to IDLE with
//      pend[k] left set, which retries the frame.
//  - Latency: frame accept -> o_start[0] is 2 cycles (pend set, IDLE->START).
//    Pool layer start -> func_start is 2 cycles minimum.
//  - Outputs are registered; every pulse is exactly one cycle wide.
//  - Simultaneous set and clear of the same pend (layer k+1 starts while layer k finishes): the
//    set wins only if the clear targets an older frame. This cannot happen, because back-pressure
//    forbids a set while pend=1. An assertion covers it.
//  - i_busy already high in START is not a new rise. WBUSY requires busy to be observed after
//    START.
//  - o_frame_cnt wraps from 2^CNT_W-1 to 0 without a flag.
//  - Reset mid-frame drops all in-flight tokens. No pulse is emitted in the reset cycle or the
//    cycle after.
// STRUCTURE
//  - Package layer_sched_pkg: typedef enum logic[2:0] seq_state_t {IDLE..ERR},
//    LENET_CIM_MASK constant, and the BUSY_TMO default.
//  - Sub-module layer_seq_fsm, instantiated NUM_LAYERS times by a generate loop.
//    - Parameter HAS_CIM.
//    - Inputs: pend_in, busy, next_busy, succ_full, clr_err.
//    - Outputs: start, func_start, done, err.
//  - The top holds pend[], the frame counter and the host handshake.
// TESTING
//  1. Reset, then one frame. Busy rises 3 cycles after each CIM start and lasts 10 cycles.
//     -> o_start[0] pulses 2 cycles after accept, then each layer's start/func pulses in order 1..7.
//     -> One o_frame_done; o_frame_cnt=1.
//  2. Three back-to-back frames with i_next_busy[4]=1 held 50 cycles.
//     -> Layers 1-4 stall in WFUNC; o_frame_ready stays 0 while pend[0]=1.
//     -> After release, all 3 complete in order; o_frame_cnt=3.
//  3. Layer 3 never raises busy. -> o_err[2]=1 exactly BUSY_TMO cycles after o_start[2].
//     -> Pulse i_clr_err, then busy behaves.
//     -> o_err clears, layer 3 restarts, and the frame completes.
//  4. Pool layers 2 and 4 with i_next_busy=0. -> o_func_start[1] follows o_start[1] by exactly 2 cycles.
//  5. Assert rst mid-frame while layer 5 is in WDONE.
//     -> All outputs are 0 asynchronously.
//     -> After release, no stale pulses and o_frame_ready=1.
//  6. Preload o_frame_cnt to 16'hFFFF via force, then complete one frame. -> o_frame_cnt=0.

Source files
------------

// File: rtl/layer_pipeline_sched_pkg.sv
// Shared types and defaults for the LeNet-5 layer-chain scheduler.
package layer_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    WBUSY,
    WDONE,
    WFUNC,
    FUNC,
    ERR
  } seq_state_t;

  localparam int         NUM_LAYERS_DEF = 7;
  localparam int         CNT_W_DEF      = 16;
  localparam int         BUSY_TMO_DEF   = 16;
  localparam logic [6:0] LENET_CIM_MASK = 7'b1110101;

endpackage

// File: rtl/layer_pipeline_sched_if.sv
// Host frame handshake plus the start/busy/next-busy pins of the layer top.
interface layer_pipeline_sched_if
  import layer_sched_pkg::*;
#(
  parameter int NUM_LAYERS = NUM_LAYERS_DEF,
  parameter int CNT_W      = CNT_W_DEF
);
  logic                  i_frame_valid;
  logic                  o_frame_ready;
  logic [NUM_LAYERS-1:0] i_busy;
  logic [NUM_LAYERS-1:0] i_next_busy;
  logic [NUM_LAYERS-1:0] o_start;
  logic [NUM_LAYERS-1:0] o_func_start;
  logic                  o_frame_done;
  logic [CNT_W-1:0]      o_frame_cnt;
  logic [NUM_LAYERS-1:0] o_err;
  logic                  i_clr_err;

  modport master (
    output i_frame_valid, i_busy, i_next_busy, i_clr_err,
    input  o_frame_ready, o_start, o_func_start, o_frame_done, o_frame_cnt, o_err
  );

  modport slave (
    input  i_frame_valid, i_busy, i_next_busy, i_clr_err,
    output o_frame_ready, o_start, o_func_start, o_frame_done, o_frame_cnt, o_err
  );
endinterface

// File: rtl/layer_pipeline_sched_fsm.sv
// Per-layer sequencer: start pulse, CIM busy handshake with timeout, back-pressured func pulse.
module layer_seq_fsm
  import layer_sched_pkg::*;
#(
  parameter bit HAS_CIM  = 1'b1,
  parameter int BUSY_TMO = BUSY_TMO_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic pend_in,
  input  logic busy,
  input  logic next_busy,
  input  logic succ_full,
  input  logic clr_err,
  output logic start,
  output logic func_start,
  output logic done,
  output logic err
);
  localparam int               TMO_W    = $clog2(BUSY_TMO + 1);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(BUSY_TMO - 1);

  seq_state_t       state_q;
  logic [TMO_W-1:0] tmo_q;
  logic             start_q;
  logic             func_q;
  logic             err_q;

  // The timeout counter already ticks during START, so the error lands BUSY_TMO cycles after the start pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      tmo_q   <= '0;
      start_q <= 1'b0;
      func_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      start_q <= 1'b0;
      func_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (pend_in) begin
            state_q <= START;
            start_q <= 1'b1;
            tmo_q   <= '0;
          end
        end
        START: begin
          tmo_q   <= tmo_q + 1'b1;
          state_q <= HAS_CIM ? WBUSY : WFUNC;
        end
        WBUSY: begin
          if (busy) begin
            state_q <= WDONE;
          end else if (tmo_q == TMO_LAST) begin
            state_q <= ERR;
            err_q   <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        WDONE: if (!busy) state_q <= WFUNC;
        WFUNC: begin
          if (!next_busy && !succ_full) begin
            state_q <= FUNC;
            func_q  <= 1'b1;
          end
        end
        FUNC:  state_q <= IDLE;
        ERR: begin
          if (clr_err) begin
            state_q <= IDLE;
            err_q   <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign start      = start_q;
  assign func_start = func_q;
  assign done       = func_q;
  assign err        = err_q;
endmodule

// File: rtl/layer_pipeline_sched.sv
// Layer-chain scheduler: frame tokens in per-layer input buffers, host handshake, frame counter.
module layer_pipeline_sched
  import layer_sched_pkg::*;
#(
  parameter int                    NUM_LAYERS = NUM_LAYERS_DEF,
  parameter logic [NUM_LAYERS-1:0] CIM_MASK   = LENET_CIM_MASK,
  parameter int                    BUSY_TMO   = BUSY_TMO_DEF,
  parameter int                    CNT_W      = CNT_W_DEF
) (
  input logic                   clk,
  input logic                   rst,
  layer_pipeline_sched_if.slave bus
);
  logic [NUM_LAYERS-1:0] pend_q, pend_d, pend_set;
  logic [NUM_LAYERS-1:0] start_w, func_w, done_w, err_w, succ_full;
  logic                  ready_q;
  logic                  accept;
  logic [CNT_W-1:0]      cnt_q, cnt_d;

  assign accept    = bus.i_frame_valid & ready_q;
  assign succ_full = {1'b0, pend_q[NUM_LAYERS-1:1]};

  // Clearing an errored layer re-arms its input buffer so the dropped frame is retried.
  always_comb begin
    pend_set = {done_w[NUM_LAYERS-2:0], accept} | (err_w & {NUM_LAYERS{bus.i_clr_err}});
    pend_d   = (pend_q & ~start_w) | pend_set;
    cnt_d    = cnt_q + CNT_W'(done_w[NUM_LAYERS-1]);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pend_q  <= '0;
      ready_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      pend_q  <= pend_d;
      ready_q <= !pend_d[0];
      cnt_q   <= cnt_d;
    end
  end

  for (genvar k = 0; k < NUM_LAYERS; k++) begin : g_layer
    layer_seq_fsm #(
      .HAS_CIM  (CIM_MASK[k]),
      .BUSY_TMO (BUSY_TMO)
    ) u_fsm (
      .clk        (clk),
      .rst        (rst),
      .pend_in    (pend_q[k]),
      .busy       (bus.i_busy[k]),
      .next_busy  (bus.i_next_busy[k]),
      .succ_full  (succ_full[k]),
      .clr_err    (bus.i_clr_err),
      .start      (start_w[k]),
      .func_start (func_w[k]),
      .done       (done_w[k]),
      .err        (err_w[k])
    );
  end

  // A predecessor may only hand over a frame into an empty buffer that is not being consumed.
  for (genvar k = 1; k < NUM_LAYERS; k++) begin : g_pend_chk
    a_no_overwrite: assert property (@(posedge clk) disable iff (!rst)
      !(done_w[k-1] && (pend_q[k] || start_w[k])));
  end

  assign bus.o_frame_ready = ready_q;
  assign bus.o_start       = start_w;
  assign bus.o_func_start  = func_w;
  assign bus.o_frame_done  = done_w[NUM_LAYERS-1];
  assign bus.o_frame_cnt   = cnt_q;
  assign bus.o_err         = err_w;
endmodule

// File: tb/tb_layer_pipeline_sched.sv
// Directed bench for layer_pipeline_sched with a per-layer busy responder and event monitor.
module tb_layer_pipeline_sched;
  import layer_sched_pkg::*;

  localparam int            NL   = 7;
  localparam int            CW   = 16;
  localparam int            TMO  = 16;
  localparam logic [NL-1:0] MASK = 7'b1110101;

  logic clk = 1'b0;
  logic rst = 1'b1;

  layer_pipeline_sched_if #(.NUM_LAYERS(NL), .CNT_W(CW)) bus();

  layer_pipeline_sched #(
    .NUM_LAYERS (NL),
    .CIM_MASK   (MASK),
    .BUSY_TMO   (TMO),
    .CNT_W      (CW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_pass   = 0;
  logic [CW-1:0] exp_cnt = '0;

  task automatic check(input string name, input longint act, input longint exp);
    n_checks++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  // Busy responder: CIM busy high from 3 to 12 cycles after each start pulse.
  int            age[NL] = '{default: -1};
  logic [NL-1:0] mute    = '0;
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (!rst) age[k] = -1;
      else if (bus.o_start[k]) age[k] = 0;
      else if (age[k] >= 12) age[k] = -1;
      else if (age[k] >= 0) age[k] = age[k] + 1;
      bus.i_busy[k] = MASK[k] && !mute[k] && (age[k] >= 3) && (age[k] <= 12);
    end
  end

  int            start_t[NL] = '{default: 0};
  int            func_t[NL]  = '{default: 0};
  int            err_t[NL]   = '{default: 0};
  int            n_start[NL] = '{default: 0};
  int            n_func[NL]  = '{default: 0};
  int            done_t = 0, n_done = 0, viol = 0;
  logic [NL-1:0] prev_start = '0, prev_func = '0, prev_err = '0;
  logic          prev_done = 1'b0;
  always @(negedge clk) begin
    for (int k = 0; k < NL; k++) begin
      if (bus.o_start[k])      begin start_t[k] = cyc; n_start[k]++; end
      if (bus.o_func_start[k]) begin func_t[k]  = cyc; n_func[k]++;  end
      if (bus.o_err[k] && !prev_err[k]) err_t[k] = cyc;
    end
    if (bus.o_frame_done) begin done_t = cyc; n_done++; end
    if ((|(bus.o_start & prev_start)) || (|(bus.o_func_start & prev_func)) ||
        (bus.o_frame_done && prev_done)) viol++;
    prev_start = bus.o_start;
    prev_func  = bus.o_func_start;
    prev_err   = bus.o_err;
    prev_done  = bus.o_frame_done;
  end

  function automatic int evcount(input int sel, input int k);
    case (sel)
      0:       return n_start[k];
      1:       return n_func[k];
      2:       return n_done;
      default: return int'(bus.o_err[k]);
    endcase
  endfunction

  function automatic int total_pulses();
    int s = n_done;
    for (int k = 0; k < NL; k++) s += n_start[k] + n_func[k];
    return s;
  endfunction

  task automatic wait_ev(input int sel, input int k, input int target, input int limit,
                         input string name);
    int i = 0;
    while (evcount(sel, k) < target && i < limit) begin step(); i++; end
    if (evcount(sel, k) < target) check(name, evcount(sel, k), target);
  endtask

  task automatic send_frame(output int a);
    int i = 0;
    while (!bus.o_frame_ready && i < 200) begin step(); i++; end
    if (!bus.o_frame_ready) check("ready_wait_timeout", 0, 1);
    bus.i_frame_valid = 1'b1;
    a = cyc;
    step();
    bus.i_frame_valid = 1'b0;
    exp_cnt++;
  endtask

  typedef struct {
    int layer;
    int rel_start;
    int rel_func;
  } vec_t;
  vec_t tbl[NL];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int a, a2, a3, r, c, d0, s2, s4, f4, p;
    // Hand timeline for one frame, cycles after accept: CIM start->func 15, pool 2, func->next start 2.
    tbl[0] = '{1,  2, 17};
    tbl[1] = '{2, 19, 21};
    tbl[2] = '{3, 23, 38};
    tbl[3] = '{4, 40, 42};
    tbl[4] = '{5, 44, 59};
    tbl[5] = '{6, 61, 76};
    tbl[6] = '{7, 78, 93};

    bus.i_frame_valid = 1'b0;
    bus.i_next_busy   = '0;
    bus.i_clr_err     = 1'b0;
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    check("reset_outputs", {bus.o_start, bus.o_func_start, bus.o_frame_done, bus.o_err,
                            bus.o_frame_ready, bus.o_frame_cnt}, 0);
    rst = 1'b1;
    step();
    check("ready_after_reset", bus.o_frame_ready, 1);
    check("err_after_reset", bus.o_err, 0);

    // Single frame through all seven layers.
    d0 = n_done;
    send_frame(a);
    wait_ev(2, 0, d0 + 1, 300, "frame1_done_timeout");
    for (int i = 0; i < NL; i++) begin
      check($sformatf("L%0d_start_time", tbl[i].layer), start_t[tbl[i].layer-1] - a, tbl[i].rel_start);
      check($sformatf("L%0d_func_time", tbl[i].layer), func_t[tbl[i].layer-1] - a, tbl[i].rel_func);
    end
    check("frame1_done_time", done_t - a, 93);
    step();
    check("frame1_cnt", bus.o_frame_cnt, exp_cnt);
    repeat (5) step();

    // Pool layers: func follows start by exactly two cycles.
    d0 = n_done;
    send_frame(a);
    wait_ev(2, 0, d0 + 1, 300, "pool_frame_done_timeout");
    check("pool_L2_gap", func_t[1] - start_t[1], 2);
    check("pool_L4_gap", func_t[3] - start_t[3], 2);
    step();
    repeat (5) step();

    // Three frames with layer 5 held off by its downstream.
    bus.i_next_busy[4] = 1'b1;
    s4 = n_start[4];
    f4 = n_func[4];
    d0 = n_done;
    send_frame(a);
    send_frame(a2);
    send_frame(a3);
    check("bp_accept2_gap", a2 - a, 3);
    check("bp_accept3_gap", a3 - a, 20);
    repeat (5) step();
    check("bp_ready_low_while_pend0", bus.o_frame_ready, 0);
    wait_ev(0, 4, s4 + 1, 200, "bp_L5_start_timeout");
    repeat (50) step();
    check("bp_L5_stalled", n_func[4] - f4, 0);
    check("bp_no_done_during_stall", n_done - d0, 0);
    bus.i_next_busy[4] = 1'b0;
    r = cyc;
    wait_ev(1, 4, f4 + 1, 20, "bp_L5_func_timeout");
    check("bp_L5_release_latency", func_t[4] - r, 1);
    wait_ev(2, 0, d0 + 3, 600, "bp_three_done_timeout");
    check("bp_frames_done", n_done - d0, 3);
    step();
    check("bp_cnt", bus.o_frame_cnt, exp_cnt);
    repeat (5) step();

    // Layer 3 never raises busy: timeout, clear, retry.
    mute[2] = 1'b1;
    d0 = n_done;
    s2 = n_start[2];
    send_frame(a);
    wait_ev(3, 2, 1, 150, "err_rise_timeout");
    check("err_latency", err_t[2] - start_t[2], TMO);
    check("err_vector", bus.o_err, 7'b0000100);
    repeat (3) step();
    check("err_sticky", bus.o_err, 7'b0000100);
    mute[2] = 1'b0;
    bus.i_clr_err = 1'b1;
    c = cyc;
    step();
    bus.i_clr_err = 1'b0;
    check("err_cleared", bus.o_err, 0);
    wait_ev(0, 2, s2 + 2, 20, "retry_start_timeout");
    check("retry_start_latency", start_t[2] - c, 2);
    wait_ev(2, 0, d0 + 1, 300, "retry_done_timeout");
    check("retry_frame_done", n_done - d0, 1);
    step();
    check("retry_cnt", bus.o_frame_cnt, exp_cnt);
    repeat (5) step();

    // Asynchronous reset while layer 5 is in WDONE.
    s4 = n_start[4];
    send_frame(a);
    while (cyc < a + 50) step();
    check("rst_L5_in_flight", n_start[4] - s4, 1);
    #2 rst = 1'b0;
    #1;
    check("rst_async_outputs", {bus.o_start, bus.o_func_start, bus.o_frame_done, bus.o_err,
                                bus.o_frame_ready, bus.o_frame_cnt}, 0);
    exp_cnt = '0;
    p = total_pulses();
    step();
    step();
    rst = 1'b1;
    step();
    check("rst_ready_after_release", bus.o_frame_ready, 1);
    repeat (20) step();
    check("rst_no_stale_pulses", total_pulses() - p, 0);
    check("rst_cnt_zero", bus.o_frame_cnt, 0);

    // Counter wrap.
    force u_dut.cnt_q = 16'hFFFF;
    step();
    release u_dut.cnt_q;
    step();
    check("cnt_preload", bus.o_frame_cnt, 16'hFFFF);
    exp_cnt = 16'hFFFF;
    d0 = n_done;
    send_frame(a);
    wait_ev(2, 0, d0 + 1, 300, "wrap_done_timeout");
    step();
    check("cnt_wrap", bus.o_frame_cnt, exp_cnt);

    check("pulse_width_violations", viol, 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
